// File: rtl/repetition_block_corrector.sv
// Majority-vote corrector for repetition-coded blocks behind a single
// valid/ready output register.
//
// Optional counters: define REPETITION_BLOCK_CORRECTOR_COUNTERS_EN.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   block_valid/ready   input block handshake
//   block               REPETITION copies, copy i at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_valid/ready    output word handshake
//   data                corrected word
//   data_corrected      a minority was outvoted on some bit
//   data_uncorrectable  some bit tied (even REPETITION only)
//   clear               sync clear of counters         (counters build)
//   corrected_count     accepted blocks with corrected (counters build)
//   uncorrectable_count accepted blocks with a tie     (counters build)
module repetition_block_corrector #(
  parameter int DATA_WIDTH    = 8,
  parameter int REPETITION    = 3,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             block_valid,
  input  logic [REPETITION*DATA_WIDTH-1:0] block,
  output logic                             block_ready,
  output logic                             data_valid,
  output logic [DATA_WIDTH-1:0]            data,
  output logic                             data_corrected,
  output logic                             data_uncorrectable,
  input  logic                             data_ready
`ifdef REPETITION_BLOCK_CORRECTOR_COUNTERS_EN
  ,
  input  logic                             clear,
  output logic [COUNTER_WIDTH-1:0]         corrected_count,
  output logic [COUNTER_WIDTH-1:0]         uncorrectable_count
`endif
);

  localparam int  OnesW = $clog2(REPETITION + 1);
  localparam int  Half  = REPETITION / 2;
  localparam bit  Even  = (REPETITION % 2) == 0;

  localparam logic [OnesW-1:0] HalfV = OnesW'(Half);
  localparam logic [OnesW-1:0] AllV  = OnesW'(REPETITION);

  if (REPETITION < 2 || COUNTER_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_param
    $error("repetition_block_corrector: invalid parameters");
  end

  logic [OnesW-1:0]      ones [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] vote;
  logic [DATA_WIDTH-1:0] tie;
  logic [DATA_WIDTH-1:0] disagree;
  logic                  vote_corrected;
  logic                  vote_uncorrectable;
  logic                  accept;

  // Population count of each bit position across all copies.
  always_comb begin
    for (int b = 0; b < DATA_WIDTH; b++) begin
      ones[b] = '0;
      for (int i = 0; i < REPETITION; i++) begin
        ones[b] = ones[b] + OnesW'(block[i*DATA_WIDTH+b]);
      end
    end
  end

  // Strict majority wins; an exact half split (even only) falls back
  // to copy 0 and is flagged as a tie.
  always_comb begin
    vote     = '0;
    tie      = '0;
    disagree = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      disagree[b] = (ones[b] != '0) && (ones[b] != AllV);
      if (ones[b] > HalfV) begin
        vote[b] = 1'b1;
      end else if (Even && ones[b] == HalfV) begin
        vote[b] = block[b];
        tie[b]  = 1'b1;
      end else begin
        vote[b] = 1'b0;
      end
    end
  end

  assign vote_corrected     = |(disagree & ~tie);
  assign vote_uncorrectable = |tie;

  // Output register: hold while stalled, reload or drain otherwise.
  logic                  data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  corrected_q, corrected_d;
  logic                  uncorrectable_q, uncorrectable_d;

  assign block_ready = ~data_valid_q | data_ready;
  assign accept      = block_valid & block_ready;

  always_comb begin
    data_valid_d    = data_valid_q;
    data_d          = data_q;
    corrected_d     = corrected_q;
    uncorrectable_d = uncorrectable_q;
    if (accept) begin
      data_valid_d    = 1'b1;
      data_d          = vote;
      corrected_d     = vote_corrected;
      uncorrectable_d = vote_uncorrectable;
    end else if (data_ready) begin
      data_valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_valid_q    <= 1'b0;
      data_q          <= '0;
      corrected_q     <= 1'b0;
      uncorrectable_q <= 1'b0;
    end else begin
      data_valid_q    <= data_valid_d;
      data_q          <= data_d;
      corrected_q     <= corrected_d;
      uncorrectable_q <= uncorrectable_d;
    end
  end

  assign data_valid         = data_valid_q;
  assign data               = data_q;
  assign data_corrected     = corrected_q;
  assign data_uncorrectable = uncorrectable_q;

`ifdef REPETITION_BLOCK_CORRECTOR_COUNTERS_EN
  localparam logic [COUNTER_WIDTH-1:0] CntMax = '1;

  logic [COUNTER_WIDTH-1:0] corr_cnt_q, corr_cnt_d;
  logic [COUNTER_WIDTH-1:0] unc_cnt_q, unc_cnt_d;

  // Saturating counters; clear overrides a same-cycle increment.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    unc_cnt_d  = unc_cnt_q;
    if (clear) begin
      corr_cnt_d = '0;
      unc_cnt_d  = '0;
    end else if (accept) begin
      if (vote_corrected && corr_cnt_q != CntMax) begin
        corr_cnt_d = corr_cnt_q + 1'b1;
      end
      if (vote_uncorrectable && unc_cnt_q != CntMax) begin
        unc_cnt_d = unc_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      unc_cnt_q  <= unc_cnt_d;
    end
  end

  assign corrected_count     = corr_cnt_q;
  assign uncorrectable_count = unc_cnt_q;
`endif

endmodule

// File: tb/tb_repetition_block_corrector.sv
// Bench for repetition_block_corrector: random and directed stimulus
// against a vote/handshake reference model kept in the bench.
module tb_repetition_block_corrector;

  localparam int CW = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        block_valid;
  logic [23:0] block;
  logic        block_ready;
  logic        data_valid;
  logic [7:0]  data;
  logic        data_corrected;
  logic        data_uncorrectable;
  logic        data_ready;

  logic        block2_valid;
  logic [15:0] block2;
  logic        block2_ready;
  logic        data2_valid;
  logic [7:0]  data2;
  logic        data2_corrected;
  logic        data2_uncorrectable;
  logic        data2_ready;

  logic        clear;
  logic [CW-1:0] corrected_count;
  logic [CW-1:0] uncorrectable_count;
  logic [CW-1:0] corrected_count2;
  logic [CW-1:0] uncorrectable_count2;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_corr, m_unc;
  bit       m2_valid;
  bit [7:0] m2_data;
  bit       m2_corr, m2_unc;
  int       m_cc, m_uc;

  always #5 clock = ~clock;

  repetition_block_corrector #(
    .DATA_WIDTH(8), .REPETITION(3), .COUNTER_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .block_valid(block_valid), .block(block), .block_ready(block_ready),
    .data_valid(data_valid), .data(data),
    .data_corrected(data_corrected),
    .data_uncorrectable(data_uncorrectable),
    .data_ready(data_ready)
`ifdef REPETITION_BLOCK_CORRECTOR_COUNTERS_EN
    , .clear(clear), .corrected_count(corrected_count),
    .uncorrectable_count(uncorrectable_count)
`endif
  );

  repetition_block_corrector #(
    .DATA_WIDTH(8), .REPETITION(2), .COUNTER_WIDTH(CW)
  ) dut2 (
    .clock(clock), .reset(reset),
    .block_valid(block2_valid), .block(block2), .block_ready(block2_ready),
    .data_valid(data2_valid), .data(data2),
    .data_corrected(data2_corrected),
    .data_uncorrectable(data2_uncorrectable),
    .data_ready(data2_ready)
`ifdef REPETITION_BLOCK_CORRECTOR_COUNTERS_EN
    , .clear(clear), .corrected_count(corrected_count2),
    .uncorrectable_count(uncorrectable_count2)
`endif
  );

`ifndef REPETITION_BLOCK_CORRECTOR_COUNTERS_EN
  assign corrected_count      = '0;
  assign uncorrectable_count  = '0;
  assign corrected_count2     = '0;
  assign uncorrectable_count2 = '0;
`endif

  // Majority vote from counting ones per bit with integer arithmetic.
  function automatic void ref_vote(input bit [23:0] blk, input int rep,
                                   output bit [7:0] d, output bit c,
                                   output bit u);
    d = 0; c = 0; u = 0;
    for (int b = 0; b < 8; b++) begin
      int ones = 0;
      for (int i = 0; i < rep; i++) ones += blk[i*8+b];
      if (2 * ones > rep) d[b] = 1;
      else if (2 * ones == rep) begin d[b] = blk[b]; u = 1; end
      if (ones != 0 && ones != rep && 2 * ones != rep) c = 1;
    end
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_corr = 0; m_unc = 0;
    m2_valid = 0; m2_data = 0; m2_corr = 0; m2_unc = 0;
    m_cc = 0; m_uc = 0;
  endtask

  // One clock: advance the model from current inputs, then let the DUT edge.
  task automatic step(output bit acc);
    bit [7:0] d; bit c, u; bit acc2;
    ref_vote(block, 3, d, c, u);
    acc = block_valid && (!m_valid || data_ready);
    if (clear) begin m_cc = 0; m_uc = 0; end
    else if (acc) begin
      if (c && m_cc < 3) m_cc++;
      if (u && m_uc < 3) m_uc++;
    end
    if (acc) begin m_valid = 1; m_data = d; m_corr = c; m_unc = u; end
    else if (data_ready) m_valid = 0;
    ref_vote({8'h00, block2}, 2, d, c, u);
    acc2 = block2_valid && (!m2_valid || data2_ready);
    if (acc2) begin m2_valid = 1; m2_data = d; m2_corr = c; m2_unc = u; end
    else if (data2_ready) m2_valid = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; block_valid = 0; block = '0; data_ready = 1;
    block2_valid = 0; block2 = '0; data2_ready = 1; clear = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (data_valid !== 1'b0 || data !== 8'h00 || data_corrected !== 1'b0 ||
        data_uncorrectable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h c=%b u=%b exp 0 00 0 0",
               data_valid, data, data_corrected, data_uncorrectable);
    end
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1;
    n_checks++;
    if (block_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b exp 1", block_ready);
    end
  endtask

  task automatic test_defaults();
    bit acc;
    block_valid = 1; block = {8'hA5, 8'hA5, 8'hA5}; data_ready = 1;
    step(acc);
    block_valid = 0;
    n_checks++;
    if (data_valid !== 1'b1 || data !== 8'hA5 || data_corrected !== 1'b0 ||
        data_uncorrectable !== 1'b0) begin
      n_fail++;
      $display("FAIL defaults got v=%b d=%h c=%b u=%b exp 1 a5 0 0",
               data_valid, data, data_corrected, data_uncorrectable);
    end
    step(acc);
  endtask

  task automatic test_back_to_back();
    bit acc;
    data_ready = 1;
    block_valid = 1; block = {8'hA5, 8'hA5, 8'hA4};
    step(acc);
    block = {8'h5A, 8'h0F, 8'h5A};
    n_checks++;
    if (data_valid !== 1'b1 || data !== 8'hA5 || data_corrected !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first got v=%b d=%h c=%b exp 1 a5 1",
               data_valid, data, data_corrected);
    end
    step(acc);
    block_valid = 0;
    n_checks++;
    if (data_valid !== 1'b1 || data !== 8'h5A || data_corrected !== 1'b1 ||
        data_uncorrectable !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second got v=%b d=%h c=%b u=%b exp 1 5a 1 0",
               data_valid, data, data_corrected, data_uncorrectable);
    end
    step(acc);
    n_checks++;
    if (data_valid !== 1'b0 || data !== 8'h5A) begin
      n_fail++;
      $display("FAIL drain_hold got v=%b d=%h exp 0 5a", data_valid, data);
    end
  endtask

  task automatic test_tie();
    bit acc;
    block2_valid = 1; block2 = {8'h3C, 8'h3D};
    step(acc);
    block2_valid = 0;
    n_checks++;
    if (data2_valid !== 1'b1 || data2 !== 8'h3D || data2_uncorrectable !== 1'b1 ||
        data2_corrected !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_rep2 got v=%b d=%h c=%b u=%b exp 1 3d 0 1",
               data2_valid, data2, data2_corrected, data2_uncorrectable);
    end
    for (int k = 0; k < 20; k++) begin
      block2_valid = 1; block2 = 16'($urandom);
      step(acc);
      block2_valid = 0;
      n_checks++;
      if (data2 !== m2_data || data2_corrected !== m2_corr ||
          data2_uncorrectable !== m2_unc || data2_valid !== m2_valid) begin
        n_fail++;
        $display("FAIL rep2_rand got d=%h c=%b u=%b exp %h %b %b",
                 data2, data2_corrected, data2_uncorrectable,
                 m2_data, m2_corr, m2_unc);
      end
    end
    step(acc);
  endtask

  task automatic test_random();
    bit acc;
    for (int k = 0; k < 300; k++) begin
      block_valid = 1'($urandom);
      data_ready  = ($urandom_range(0, 3) != 0);
      // mostly one flipped bit in one copy, sometimes arbitrary copies
      if ($urandom_range(0, 3) == 0) block = 24'($urandom);
      else begin
        bit [7:0] w; w = 8'($urandom);
        block = {w, w, w};
        block[$urandom_range(0, 23)] ^= 1'b1;
      end
      #1;
      n_checks++;
      if (block_ready !== (!m_valid || data_ready)) begin
        n_fail++;
        $display("FAIL rand_ready got %b exp %b", block_ready,
                 !m_valid || data_ready);
      end
      step(acc);
      n_checks++;
      if (data_valid !== m_valid ||
          (m_valid && (data !== m_data || data_corrected !== m_corr ||
                       data_uncorrectable !== m_unc))) begin
        n_fail++;
        $display("FAIL rand_out got v=%b d=%h c=%b u=%b exp %b %h %b %b",
                 data_valid, data, data_corrected, data_uncorrectable,
                 m_valid, m_data, m_corr, m_unc);
      end
    end
    block_valid = 0; data_ready = 1;
    step(acc);
  endtask

  task automatic test_backpressure();
    bit acc;
    bit [7:0] exp_q[$];
    bit [7:0] obs_q[$];
    bit [7:0] held;
    bit [7:0] d; bit c, u;
    int nblk;
    nblk = 0;
    data_ready = 1; block_valid = 1; block = 24'($urandom);
    ref_vote(block, 3, d, c, u); exp_q.push_back(d); nblk++;
    step(acc);
    held = data;
    data_ready = 0;
    for (int k = 0; k < 4; k++) begin
      block = 24'($urandom);
      #1;
      n_checks++;
      if (block_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready got %b exp 0", block_ready);
      end
      step(acc);
      n_checks++;
      if (data_valid !== 1'b1 || data !== exp_q[0] ||
          data_corrected !== m_corr || data_uncorrectable !== m_unc) begin
        n_fail++;
        $display("FAIL bp_stable got v=%b d=%h exp 1 %h", data_valid, data, held);
      end
    end
    data_ready = 1;
    for (int k = 0; k < 7; k++) begin
      block_valid = (k < 3);
      block = 24'($urandom);
      #1;
      if (data_valid && data_ready) obs_q.push_back(data);
      if (block_valid && (!m_valid || data_ready)) begin
        ref_vote(block, 3, d, c, u); exp_q.push_back(d); nblk++;
      end
      step(acc);
    end
    n_checks++;
    if (obs_q.size() != nblk) begin
      n_fail++;
      $display("FAIL bp_count got %0d exp %0d", obs_q.size(), nblk);
    end
    for (int k = 0; k < nblk && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL bp_order[%0d] got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    data_ready = 1; block_valid = 1; block = {8'h11, 8'h11, 8'h11};
    step(acc);
    data_ready = 0; block_valid = 0;
    step(acc);
    #2;
    reset = 1;
    #1;
    model_reset();
    n_checks++;
    if (data_valid !== 1'b0 || data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid got v=%b d=%h exp 0 00", data_valid, data);
    end
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1;
    n_checks++;
    if (block_ready !== 1'b1 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ready got r=%b v=%b exp 1 0",
               block_ready, data_valid);
    end
    data_ready = 1;
  endtask

`ifdef REPETITION_BLOCK_CORRECTOR_COUNTERS_EN
  task automatic test_counters();
    bit acc;
    int exp_seq[5];
    exp_seq = '{1, 2, 3, 3, 3};
    block_valid = 0; data_ready = 1; clear = 1;
    step(acc);
    clear = 0;
    n_checks++;
    if (corrected_count !== '0 || uncorrectable_count !== '0) begin
      n_fail++;
      $display("FAIL cnt_clear got %0d %0d exp 0 0",
               corrected_count, uncorrectable_count);
    end
    for (int k = 0; k < 5; k++) begin
      bit [7:0] w; w = 8'($urandom);
      block_valid = 1;
      block = {w, w, w ^ 8'h10};
      step(acc);
      n_checks++;
      if (corrected_count !== CW'(exp_seq[k]) ||
          corrected_count !== CW'(m_cc)) begin
        n_fail++;
        $display("FAIL cnt_sat[%0d] got %0d exp %0d", k,
                 corrected_count, exp_seq[k]);
      end
    end
    clear = 1; block = {8'h00, 8'h01, 8'h00};
    step(acc);
    clear = 0; block_valid = 0;
    n_checks++;
    if (corrected_count !== '0 || data_corrected !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt_clear_prio got %0d c=%b exp 0 1",
               corrected_count, data_corrected);
    end
    step(acc);
  endtask
`endif

  initial begin
    test_reset();
    test_defaults();
    test_back_to_back();
    test_tie();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef REPETITION_BLOCK_CORRECTOR_COUNTERS_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/repetition_block_corrector.md
Name: repetition_block_corrector

Overview:
- Registered majority-vote corrector for repetition-coded blocks.
- Sits directly downstream of the repetition checker, on the same block bus, and consumes the same block format.
- Each accepted block is reduced to one corrected data word with per-block corrected/uncorrectable flags.
- Output is a single-stage valid/ready pipeline register with full-throughput backpressure.

Parameters:
- DATA_WIDTH, 8, width of one data copy.
- REPETITION, 3, number of copies in a block; must be ≥2.
- COUNTER_WIDTH, 16, width of the error statistics counters (optional feature only).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- block_valid  input  1  block present on input.
- block  input  REPETITION*DATA_WIDTH  copy i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- block_ready  output  1  block accepted on block_valid & block_ready.
- data_valid  output  1  corrected word present on output.
- data  output  DATA_WIDTH  corrected word.
- data_corrected  output  1  at least one bit had a disagreeing minority that was outvoted.
- data_uncorrectable  output  1  at least one bit had a tie (even REPETITION only).
- data_ready  input  1  downstream accepts on data_valid & data_ready.

Behaviour:
- Reset, asynchronous on reset high:
  - data_valid=0, data=0, data_corrected=0, data_uncorrectable=0.
  - Counters reset to 0.
- Per bit b, ones = number of copies with bit b set, computed combinationally on the input block.
  - ones > REPETITION/2 (integer half): bit = 1.
  - ones < REPETITION - REPETITION/2 with no tie: bit = 0.
  - Even REPETITION and ones == REPETITION/2: tie; bit = copy 0 value; tie flag set for b.
  - disagree[b] = (ones != 0) & (ones != REPETITION).
  - corrected = |(disagree & ~tie).
  - uncorrectable = |tie.
  - Odd REPETITION: uncorrectable is constant 0.
- Handshake:
  - block_ready = ~data_valid | data_ready, combinational.
  - On block accept: data, data_corrected and data_uncorrectable are loaded; data_valid=1 on the next cycle (latency 1).
  - Output accepted with no new block accepted: data_valid=0; data and flags hold their last value.
  - Output accepted and new block accepted in the same cycle: register reloads and data_valid stays 1. Sustains 1 block/cycle.
  - data_valid=1 & data_ready=0: output registers hold stable; block_ready=0.
  - block must be sampled only when block_valid & block_ready; values on invalid cycles are ignored.
- Reset mid-transfer: the pending output word is dropped with no flush. block_ready=1 from the first cycle after reset deasserts.

Optional Feature:
- Macro: REPETITION_BLOCK_CORRECTOR_COUNTERS_EN.
- When defined, these ports are added:
  - clear  input  1  synchronous clear of both counters.
  - corrected_count  output  COUNTER_WIDTH  number of accepted blocks with corrected=1.
  - uncorrectable_count  output  COUNTER_WIDTH  number of accepted blocks with uncorrectable=1.
- Counter rules:
  - Counters increment on block accept, in the same cycle the output register loads.
  - Counters saturate at all-ones and do not wrap.
  - clear has priority over an increment in the same cycle; the result is 0.
- When undefined: the ports and counter logic are absent and the rest of the behaviour is identical.

Test Plan:
- Defaults: block={8'hA5,8'hA5,8'hA5}, data_ready=1 → next cycle data=8'hA5, corrected=0, uncorrectable=0, data_valid=1.
- block={8'hA5,8'hA5,8'hA4} (copy 0 bit 0 flipped), then {8'h5A,8'h0F,8'h5A} → data=8'hA5 corrected=1, then data=8'h5A corrected=1. Back-to-back with no bubble.
- REPETITION=2: block={8'h3C,8'h3D} → data=8'h3D (copy 0 value), uncorrectable=1, corrected=0.
- Backpressure: data_ready=0 for 4 cycles with block_valid=1 and changing block → block_ready=0, data and flags stable. Release → exactly one word per accepted block, in order, none lost or duplicated.
- Assert reset while data_valid=1 and data_ready=0 → data_valid=0 immediately, data=0, block_ready=1 after reset release.
- COUNTERS_EN with COUNTER_WIDTH=2: 5 corrected blocks → corrected_count 1,2,3,3,3. Pulse clear coincident with a 6th corrected block → corrected_count=0.
